// File: rtl/calc_pkg.sv
// Shared constants and types for the keypad calculator sequencer.
package calc_pkg;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_CONV = 2'b10,
    S_RES  = 2'b11
  } state_t;

  localparam logic [3:0] KEY_ADD = 4'hA;
  localparam logic [3:0] KEY_SUB = 4'hB;
  localparam logic [3:0] KEY_EQ  = 4'hE;
  localparam logic [3:0] KEY_CLR = 4'hF;

  localparam logic [7:0] C100 = 8'd100;
  localparam logic [7:0] C10  = 8'd10;

  // tens*10 + ones, written as tens*8 + tens*2 + ones
  function automatic logic [6:0] bcd2bin(
    input logic [3:0] tn,
    input logic [3:0] on
  );
    return {tn, 3'b000}
         + {2'b00, tn, 1'b0}
         + {3'b000, on};
  endfunction

endpackage

// File: rtl/calc_seq_ctrl_bin2bcd_seq.sv
// Subtract-loop binary to BCD converter, one step per clock.
module bin2bcd_seq
  import calc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       clr,
  input  logic [7:0] bin,
  output logic       busy,
  output logic       done,
  output logic [3:0] h,
  output logic [3:0] t,
  output logic [3:0] o
);

  logic [7:0] r_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      h     <= '0;
      t     <= '0;
      o     <= '0;
    end else if (clr) begin
      r_val <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      h     <= '0;
      t     <= '0;
      o     <= '0;
    end else if (start) begin
      r_val <= bin;
      busy  <= 1'b1;
      done  <= 1'b0;
      h     <= '0;
      t     <= '0;
      o     <= '0;
    end else if (busy) begin
      if (r_val >= C100) begin
        r_val <= r_val - C100;
        h     <= h + 4'd1;
      end else if (r_val >= C10) begin
        r_val <= r_val - C10;
        t     <= t + 4'd1;
      end else begin
        o    <= r_val[3:0];
        busy <= 1'b0;
        done <= 1'b1;
      end
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Key FSM, operand registers and display mux for the calculator.
module calc_seq_ctrl
  import calc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [1:0]  state,
  output logic        busy,
  output logic        op_sub,
  output logic [15:0] disp,
  output logic        neg,
  output logic        done
);

  state_t     r_state;
  logic [3:0] r_a_t;
  logic [3:0] r_a_o;
  logic [1:0] r_a_n;
  logic [3:0] r_b_t;
  logic [3:0] r_b_o;
  logic [1:0] r_b_n;
  logic       r_op;
  logic       r_neg;

  logic       w_busy;
  logic       w_done;
  logic [3:0] w_h;
  logic [3:0] w_t;
  logic [3:0] w_o;
  logic       w_clr;
  logic       w_start;
  logic       w_digit;
  logic       w_op;
  logic [6:0] w_a;
  logic [6:0] w_b;
  logic       w_lt;
  logic [6:0] w_diff;
  logic [7:0] w_sum;
  logic [7:0] w_bin;
  logic [1:0] w_state;

  assign w_clr   = key_valid && key_code == KEY_CLR;
  assign w_digit = key_code < 4'd10;
  assign w_op    = key_code == KEY_ADD
                || key_code == KEY_SUB;
  assign w_start = key_valid && !w_busy
                && r_state == S_B
                && key_code == KEY_EQ;

  assign w_a    = bcd2bin(r_a_t, r_a_o);
  assign w_b    = bcd2bin(r_b_t, r_b_o);
  assign w_lt   = w_a < w_b;
  assign w_diff = w_lt ? w_b - w_a : w_a - w_b;
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_bin  = r_op ? {1'b0, w_diff} : w_sum;

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_start),
    .clr   (w_clr),
    .bin   (w_bin),
    .busy  (w_busy),
    .done  (w_done),
    .h     (w_h),
    .t     (w_t),
    .o     (w_o)
  );

  // r_state already holds S_RES while the converter runs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_A;
      r_a_t   <= '0;
      r_a_o   <= '0;
      r_a_n   <= '0;
      r_b_t   <= '0;
      r_b_o   <= '0;
      r_b_n   <= '0;
      r_op    <= 1'b0;
      r_neg   <= 1'b0;
    end else if (w_clr) begin
      r_state <= S_A;
      r_a_t   <= '0;
      r_a_o   <= '0;
      r_a_n   <= '0;
      r_b_t   <= '0;
      r_b_o   <= '0;
      r_b_n   <= '0;
      r_op    <= 1'b0;
      r_neg   <= 1'b0;
    end else if (!w_busy) begin
      unique case (r_state)
        S_A: begin
          if (key_valid && w_digit) begin
            if (r_a_n < 2'd2) begin
              r_a_t <= r_a_o;
              r_a_o <= key_code;
              r_a_n <= r_a_n + 2'd1;
            end
          end else if (key_valid && w_op) begin
            r_op    <= key_code == KEY_SUB;
            r_b_t   <= '0;
            r_b_o   <= '0;
            r_b_n   <= '0;
            r_state <= S_B;
          end
        end
        S_B: begin
          if (key_valid && w_digit) begin
            if (r_b_n < 2'd2) begin
              r_b_t <= r_b_o;
              r_b_o <= key_code;
              r_b_n <= r_b_n + 2'd1;
            end
          end else if (key_valid && w_op) begin
            r_op <= key_code == KEY_SUB;
          end else if (w_start) begin
            r_neg   <= r_op && w_lt;
            r_state <= S_RES;
          end
        end
        S_RES: begin
          if (key_valid && w_digit) begin
            r_a_t   <= '0;
            r_a_o   <= key_code;
            r_a_n   <= 2'd1;
            r_b_t   <= '0;
            r_b_o   <= '0;
            r_b_n   <= '0;
            r_neg   <= 1'b0;
            r_state <= S_A;
          end
        end
        default: r_state <= S_A;
      endcase
    end
  end

  assign w_state = w_busy ? S_CONV : r_state;
  assign state   = w_state;
  assign busy    = w_busy;
  assign op_sub  = r_op;
  assign done    = w_done;
  assign neg     = (w_state == S_RES) && r_neg;

  always_comb begin
    disp = 16'h0000;
    unique case (w_state)
      S_A:     disp = {8'h00, r_a_t, r_a_o};
      S_B:     disp = {8'h00, r_b_t, r_b_o};
      S_CONV:  disp = {8'h00, r_b_t, r_b_o};
      S_RES:   disp = {4'h0, w_h, w_t, w_o};
      default: disp = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl with an arithmetic reference model.
module tb_calc_seq_ctrl;

  logic        clk;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [1:0]  state;
  logic        busy;
  logic        op_sub;
  logic [15:0] disp;
  logic        neg;
  logic        done;

  calc_seq_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .state     (state),
    .busy      (busy),
    .op_sub    (op_sub),
    .disp      (disp),
    .neg       (neg),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          at_edge;
    logic [15:0] d;
    logic        n;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // phase: 0 entering A, 1 entering B, 2 converting, 3 result
  int mA, mAc, mB, mBc, mph, mop, mneg, mres, mcnt;

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (edge %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] dec2(input int v);
    return {8'h00, 4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] dec3(input int v);
    return {4'h0, 4'(v / 100),
            4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] mdisp();
    case (mph)
      0:       return dec2(mA);
      1, 2:    return dec2(mB);
      default: return dec3(mres);
    endcase
  endfunction

  task automatic model_reset();
    mA = 0; mAc = 0; mB = 0; mBc = 0;
    mph = 0; mop = 0; mneg = 0; mres = 0; mcnt = 0;
    sb.delete();
  endtask

  task automatic model_edge(input bit v, input logic [3:0] k);
    int r;
    exp_t e;
    if (v && k == 4'hF) begin
      model_reset();
      return;
    end
    if (mph == 2) begin
      mcnt--;
      if (mcnt == 0) mph = 3;
      return;
    end
    if (!v) return;
    if (k <= 4'd9) begin
      if (mph == 0 && mAc < 2) begin
        mA = (mA % 10) * 10 + int'(k); mAc++;
      end else if (mph == 1 && mBc < 2) begin
        mB = (mB % 10) * 10 + int'(k); mBc++;
      end else if (mph == 3) begin
        mA = int'(k); mAc = 1; mB = 0; mBc = 0;
        mph = 0;
      end
    end else if (k == 4'hA || k == 4'hB) begin
      if (mph == 0) begin
        mop = (k == 4'hB); mB = 0; mBc = 0; mph = 1;
      end else if (mph == 1) begin
        mop = (k == 4'hB);
      end
    end else if (k == 4'hE && mph == 1) begin
      r = mop ? mA - mB : mA + mB;
      mneg = (r < 0);
      mres = (r < 0) ? -r : r;
      mcnt = mres / 100 + (mres % 100) / 10 + 1;
      mph = 2;
      e.at_edge = cyc + mcnt;
      e.d = dec3(mres);
      e.n = 1'(mneg);
      sb.push_back(e);
    end
  endtask

  task automatic drive(input bit v, input logic [3:0] k);
    @(negedge clk);
    key_valid = v;
    key_code  = k;
    @(posedge clk);
    cyc++;
    model_edge(v, k);
  endtask

  task automatic press(input logic [3:0] k);
    drive(1'b1, k);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 4'h0);
  endtask

  always @(negedge clk) begin
    chk("state", {14'b0, state}, 16'(mph));
    chk("busy", {15'b0, busy}, 16'(mph == 2));
    chk("op_sub", {15'b0, op_sub}, 16'(mop));
    chk("disp", disp, mdisp());
    chk("neg", {15'b0, neg}, 16'(mph == 3 && mneg != 0));
    if (sb.size() > 0 && sb[0].at_edge == cyc) begin
      chk("done_pulse", {15'b0, done}, 16'd1);
      chk("res_disp", disp, sb[0].d);
      chk("res_neg", {15'b0, neg}, {15'b0, sb[0].n});
      void'(sb.pop_front());
    end else begin
      chk("no_done", {15'b0, done}, 16'd0);
    end
  end

  initial begin
    int x;
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_code = 4'h0;
    model_reset();
    #3;
    chk("rst_state", {14'b0, state}, 16'd0);
    chk("rst_disp", disp, 16'h0000);
    chk("rst_flags", {12'b0, busy, op_sub, neg, done}, 16'd0);
    #9 rst_n = 1'b1;

    press(4'h1); press(4'h2); press(4'hA);
    press(4'h3); press(4'h4); press(4'hE);
    idle(8);
    press(4'h9); press(4'h9); press(4'hA);
    press(4'h9); press(4'h9); press(4'hE);
    idle(13);
    press(4'h1); press(4'h5); press(4'hB);
    press(4'h4); press(4'h2); press(4'hE);
    idle(6);
    press(4'h4); press(4'h2); press(4'hB);
    press(4'h4); press(4'h2); press(4'hE);
    idle(3);
    press(4'hF);
    press(4'hE); press(4'h1); press(4'h2); press(4'h3);
    press(4'hA); press(4'hB); press(4'h6); press(4'hE);
    idle(4);
    press(4'h9); press(4'h9); press(4'hA);
    press(4'h9); press(4'h9); press(4'hE);
    idle(2);
    press(4'hF);
    idle(14);
    press(4'h1); press(4'h2); press(4'hA);
    press(4'h3); press(4'h4); press(4'hE);
    idle(7);
    press(4'h7); press(4'h3);

    // asynchronous reset between clock edges
    #3;
    rst_n = 1'b0;
    key_valid = 1'b0;
    #1;
    chk("async_state", {14'b0, state}, 16'd0);
    chk("async_disp", disp, 16'h0000);
    chk("async_flags", {12'b0, busy, op_sub, neg, done}, 16'd0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 3000; i++) begin
      x = $urandom_range(0, 99);
      if (x < 50) press(4'($urandom_range(0, 9)));
      else if (x < 62) press($urandom_range(0, 1) ? 4'hA : 4'hB);
      else if (x < 72) press(4'hE);
      else if (x < 75) press(4'hF);
      else if (x < 79) press($urandom_range(0, 1) ? 4'hC : 4'hD);
      else idle(1);
    end
    idle(15);
    chk("sb_empty", 16'(sb.size()), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
